// File: rtl/cost_table_responder_pkg.sv
// Shared assignment-engine (JAM) definitions: table geometry, widths and
// responder state encodings.
package cost_table_responder_pkg;

    localparam int JAM_POINT_ADDR = 3;
    localparam int JAM_COST_W     = 7;
    localparam int JAM_SUM_W      = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SUM   = 3'd2,
        ST_SERVE = 3'd3,
        ST_HOLD  = 3'd4
    } ctr_state_e;

endpackage

// File: rtl/cost_table_responder_row_min.sv
// Running minimum over one table row; publishes the row minimum on the row's
// last accepted beat.
module cost_row_min #(
    parameter int COST_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              beat_i,
    input  logic              first_i,
    input  logic              last_i,
    input  logic [COST_W-1:0] data_i,
    output logic              commit_o,
    output logic [COST_W-1:0] min_o
);

    logic [COST_W-1:0] run_q;
    logic [COST_W-1:0] run_d;

    // The first column restarts the minimum so earlier rows never leak in.
    always_comb begin
        run_d = run_q;
        if (first_i || (data_i < run_q)) begin
            run_d = data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= '0;
        end else if (beat_i) begin
            run_q <= run_d;
        end
    end

    assign commit_o = beat_i && last_i;
    assign min_o    = run_d;

endmodule

// File: rtl/cost_table_responder.sv
// Cost-table responder: streams in an NxN cost table, computes the sum of row
// minima as a lower bound, serves lookups and captures one engine result.
module cost_table_responder
    import cost_table_responder_pkg::*;
#(
    parameter int POINT_ADDR = JAM_POINT_ADDR,
    parameter int COST_W     = JAM_COST_W,
    parameter int SUM_W      = JAM_SUM_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  LdValid,
    output logic                  LdReady,
    input  logic [COST_W-1:0]     LdData,
    input  logic [POINT_ADDR-1:0] W,
    input  logic [POINT_ADDR-1:0] J,
    output logic [COST_W-1:0]     Cost,
    input  logic                  Valid,
    input  logic [3:0]            MatchCount,
    input  logic [SUM_W-1:0]      MinCost,
    output logic                  TableReady,
    output logic [SUM_W-1:0]      LowerBound,
    output logic                  Done,
    output logic [SUM_W-1:0]      ResMinCost,
    output logic [3:0]            ResMatchCount,
    output logic                  BoundOk
);

    localparam int AW      = 2 * POINT_ADDR;
    localparam int ROWS    = 1 << POINT_ADDR;
    localparam int ENTRIES = 1 << AW;

    ctr_state_e state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [POINT_ADDR-1:0] sum_cnt_q, sum_cnt_d;
    logic [SUM_W-1:0]      acc_q, acc_d;
    logic [SUM_W-1:0]      lb_q, lb_d;
    logic [SUM_W-1:0]      res_cost_q, res_cost_d;
    logic [3:0]            res_cnt_q, res_cnt_d;
    logic                  done_q, done_d;
    logic                  bok_q, bok_d;

    logic [COST_W-1:0] tbl    [ENTRIES];
    logic [COST_W-1:0] rowmin [ROWS];

    logic                  beat;
    logic [POINT_ADDR-1:0] col, row;
    logic                  rm_commit;
    logic [COST_W-1:0]     rm_min;
    logic                  serving;

    assign beat    = LdValid && (state_q == ST_LOAD);
    assign col     = addr_q[POINT_ADDR-1:0];
    assign row     = addr_q[AW-1:POINT_ADDR];
    assign serving = (state_q == ST_SERVE) || (state_q == ST_HOLD);

    cost_row_min #(
        .COST_W (COST_W)
    ) u_row_min (
        .clk      (CLK),
        .rst_n    (RST),
        .beat_i   (beat),
        .first_i  (col == '0),
        .last_i   (&col),
        .data_i   (LdData),
        .commit_o (rm_commit),
        .min_o    (rm_min)
    );

    // Table storage is deliberately unreset; a fresh load overwrites it.
    always_ff @(posedge CLK) begin
        if (beat) begin
            tbl[addr_q] <= LdData;
        end
        if (rm_commit) begin
            rowmin[row] <= rm_min;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        sum_cnt_d  = sum_cnt_q;
        acc_d      = acc_q;
        lb_d       = lb_q;
        res_cost_d = res_cost_q;
        res_cnt_d  = res_cnt_q;
        done_d     = done_q;
        bok_d      = bok_q;
        case (state_q)
            ST_IDLE: begin
                addr_d  = '0;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (beat) begin
                    addr_d = addr_q + AW'(1);
                    if (&addr_q) begin
                        acc_d     = '0;
                        sum_cnt_d = '0;
                        state_d   = ST_SUM;
                    end
                end
            end
            ST_SUM: begin
                acc_d     = acc_q + {{(SUM_W-COST_W){1'b0}}, rowmin[sum_cnt_q]};
                sum_cnt_d = sum_cnt_q + POINT_ADDR'(1);
                if (&sum_cnt_q) begin
                    lb_d    = acc_d;
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                // A result strobe takes priority over a reload request.
                if (Valid) begin
                    res_cost_d = MinCost;
                    res_cnt_d  = MatchCount;
                    bok_d      = (MinCost >= lb_q);
                    done_d     = 1'b1;
                    state_d    = ST_HOLD;
                end else if (LdValid) begin
                    addr_d  = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_HOLD: begin
                if (LdValid) begin
                    addr_d  = '0;
                    done_d  = 1'b0;
                    bok_d   = 1'b0;
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            sum_cnt_q  <= '0;
            acc_q      <= '0;
            lb_q       <= '0;
            res_cost_q <= '0;
            res_cnt_q  <= '0;
            done_q     <= 1'b0;
            bok_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            sum_cnt_q  <= sum_cnt_d;
            acc_q      <= acc_d;
            lb_q       <= lb_d;
            res_cost_q <= res_cost_d;
            res_cnt_q  <= res_cnt_d;
            done_q     <= done_d;
            bok_q      <= bok_d;
        end
    end

    assign LdReady       = (state_q == ST_LOAD);
    assign TableReady    = serving;
    assign Cost          = serving ? tbl[{W, J}] : '0;
    assign LowerBound    = lb_q;
    assign Done          = done_q;
    assign ResMinCost    = res_cost_q;
    assign ResMatchCount = res_cnt_q;
    assign BoundOk       = bok_q;

endmodule

// File: tb/tb_cost_table_responder.sv
// Directed bench for cost_table_responder: load patterns, lower bound, lookup,
// result capture, reload and mid-load reset.
module tb_cost_table_responder;

    logic       CLK = 1'b0;
    logic       RST;
    logic       LdValid;
    logic       LdReady;
    logic [6:0] LdData;
    logic [2:0] W, J;
    logic [6:0] Cost;
    logic       Valid;
    logic [3:0] MatchCount;
    logic [9:0] MinCost;
    logic       TableReady;
    logic [9:0] LowerBound;
    logic       Done;
    logic [9:0] ResMinCost;
    logic [3:0] ResMatchCount;
    logic       BoundOk;

    int vectors = 0;
    int errs    = 0;

    cost_table_responder dut (
        .CLK           (CLK),
        .RST           (RST),
        .LdValid       (LdValid),
        .LdReady       (LdReady),
        .LdData        (LdData),
        .W             (W),
        .J             (J),
        .Cost          (Cost),
        .Valid         (Valid),
        .MatchCount    (MatchCount),
        .MinCost       (MinCost),
        .TableReady    (TableReady),
        .LowerBound    (LowerBound),
        .Done          (Done),
        .ResMinCost    (ResMinCost),
        .ResMatchCount (ResMatchCount),
        .BoundOk       (BoundOk)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Each beat: value = idx+1 (pattern) or a constant; optional idle gap.
    task automatic load(input int nbeats, input bit pattern, input int cval, input bit gap);
        for (int i = 0; i < nbeats; i++) begin
            LdValid = 1'b1;
            LdData  = pattern ? 7'(i + 1) : 7'(cval);
            tick();
            if (gap) begin
                LdValid = 1'b0;
                tick();
            end
        end
        LdValid = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!TableReady && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 32'(TableReady), 1);
    endtask

    initial begin
        RST = 1'b0; LdValid = 1'b0; LdData = '0; W = '0; J = '0;
        Valid = 1'b0; MatchCount = '0; MinCost = '0;
        #1;
        repeat (2) tick();
        chk("rst_ldready",   32'(LdReady), 0);
        chk("rst_tblready",  32'(TableReady), 0);
        chk("rst_done",      32'(Done), 0);
        chk("rst_boundok",   32'(BoundOk), 0);
        chk("rst_lowerbnd",  32'(LowerBound), 0);
        chk("rst_resmin",    32'(ResMinCost), 0);
        chk("rst_rescnt",    32'(ResMatchCount), 0);
        chk("rst_cost",      32'(Cost), 0);

        RST = 1'b1;
        #1;
        chk("idle_ldready", 32'(LdReady), 0);
        tick();
        chk("load_ldready", 32'(LdReady), 1);

        // Continuous load: 64 beats then exactly 8 SUM cycles.
        load(32, 1'b1, 0, 1'b0);
        W = 3'd3; J = 3'd5; #1;
        chk("load_cost_zero", 32'(Cost), 0);
        for (int i = 32; i < 64; i++) begin
            LdValid = 1'b1; LdData = 7'(i + 1);
            tick();
        end
        LdValid = 1'b0;
        chk("sum_ldready", 32'(LdReady), 0);
        repeat (7) tick();
        chk("sum7_tblready", 32'(TableReady), 0);
        tick();
        chk("sum8_tblready", 32'(TableReady), 1);
        chk("lb_232", 32'(LowerBound), 232);
        W = 3'd3; J = 3'd5; #1;
        chk("cost_3_5", 32'(Cost), 30);
        W = 3'd7; J = 3'd7; #1;
        chk("cost_7_7", 32'(Cost), 64);
        W = 3'd0; J = 3'd0; #1;
        chk("cost_0_0", 32'(Cost), 1);

        // Result capture, BoundOk with MinCost above bound.
        Valid = 1'b1; MinCost = 10'd240; MatchCount = 4'd12; #1;
        chk("cap_done_same", 32'(Done), 0);
        tick();
        Valid = 1'b0;
        chk("cap_done", 32'(Done), 1);
        chk("cap_resmin", 32'(ResMinCost), 240);
        chk("cap_rescnt", 32'(ResMatchCount), 12);
        chk("cap_boundok", 32'(BoundOk), 1);

        // HOLD ignores further strobes and keeps serving.
        Valid = 1'b1; MinCost = 10'd5; MatchCount = 4'd3;
        tick();
        Valid = 1'b0;
        chk("hold_resmin", 32'(ResMinCost), 240);
        chk("hold_rescnt", 32'(ResMatchCount), 12);
        W = 3'd6; J = 3'd2; #1;
        chk("hold_cost_6_2", 32'(Cost), 51);

        // Reload with LdValid every other cycle from HOLD.
        LdValid = 1'b1; LdData = 7'd1; #1;
        chk("hold_ldready", 32'(LdReady), 0);
        tick();
        chk("reload_done_clr", 32'(Done), 0);
        chk("reload_bok_clr", 32'(BoundOk), 0);
        chk("reload_tblready", 32'(TableReady), 0);
        load(64, 1'b1, 0, 1'b1);
        wait_ready("gap_ready");
        chk("gap_lb_232", 32'(LowerBound), 232);
        W = 3'd3; J = 3'd5; #1;
        chk("gap_cost_3_5", 32'(Cost), 30);
        W = 3'd4; J = 3'd0; #1;
        chk("gap_cost_4_0", 32'(Cost), 33);

        // Strobe and reload request together: capture wins.
        Valid = 1'b1; MinCost = 10'd200; MatchCount = 4'd9; LdValid = 1'b1; #1;
        chk("both_ldready_same", 32'(LdReady), 0);
        tick();
        Valid = 1'b0;
        chk("both_done", 32'(Done), 1);
        chk("both_resmin", 32'(ResMinCost), 200);
        chk("both_rescnt", 32'(ResMatchCount), 9);
        chk("both_boundok", 32'(BoundOk), 0);
        chk("both_ldready", 32'(LdReady), 0);
        chk("both_tblready", 32'(TableReady), 1);

        // HOLD -> LOAD, partial load of zeros, then reset mid-load.
        tick();
        chk("part_ldready", 32'(LdReady), 1);
        load(30, 1'b0, 0, 1'b0);
        RST = 1'b0; #1;
        chk("midrst_ldready", 32'(LdReady), 0);
        chk("midrst_lb", 32'(LowerBound), 0);
        chk("midrst_done", 32'(Done), 0);
        tick();
        RST = 1'b1;
        tick();
        load(64, 1'b0, 127, 1'b0);
        repeat (8) tick();
        chk("max_tblready", 32'(TableReady), 1);
        chk("max_lb_1016", 32'(LowerBound), 1016);
        W = 3'd0; J = 3'd1; #1;
        chk("max_cost_0_1", 32'(Cost), 127);
        W = 3'd2; J = 3'd3; #1;
        chk("max_cost_2_3", 32'(Cost), 127);

        // MinCost equal to the bound still satisfies it.
        Valid = 1'b1; MinCost = 10'd1016; MatchCount = 4'd15;
        tick();
        Valid = 1'b0;
        chk("eq_done", 32'(Done), 1);
        chk("eq_boundok", 32'(BoundOk), 1);
        chk("eq_rescnt", 32'(ResMatchCount), 15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
